mem_access_stage: RTL and testbench

// - MEM pipeline stage, directly downstream of the EX/MEM register; consumes its M_* outputs.
// - Runs loads/stores against a data-memory bus with req/ack handshake, ack latency 1..N cycles.
// - Aligns store data and byte enables; extracts and extends load data; stalls the pipeline while the bus is busy.
// - Hands the WB-bound result to the MEM/WB register.

---
 rtl/cpu_mem_pkg.sv | 52 +++++
 rtl/mem_lane_align.sv | 57 +++++
 rtl/mem_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_pkg
// Brief    : Load/store option codes, MEM-stage FSM states and alignment helper
//            shared by the decoder, EX/MEM register and MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LHU = 3'd2;
    localparam logic [2:0] LOAD_LB  = 3'd3;
    localparam logic [2:0] LOAD_LBU = 3'd4;

    localparam logic [1:0] SAVE_SW  = 2'd0;
    localparam logic [1:0] SAVE_SH  = 2'd1;
    localparam logic [1:0] SAVE_SB  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Unknown option codes behave as full-word accesses, so they need word alignment.
    function automatic logic is_misaligned(
        input logic [1:0] addr_lo,
        input logic       is_store,
        input logic [2:0] load_opt,
        input logic [1:0] save_opt
    );
        logic misal;
        misal = 1'b0;
        if (is_store) begin
            case (save_opt)
                SAVE_SH: misal = addr_lo[0];
                SAVE_SB: misal = 1'b0;
                default: misal = |addr_lo;
            endcase
        end else begin
            case (load_opt)
                LOAD_LH, LOAD_LHU: misal = addr_lo[0];
                LOAD_LB, LOAD_LBU: misal = 1'b0;
                default:           misal = |addr_lo;
            endcase
        end
        return misal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Brief    : Combinational store lane replication / byte-enable generation and
//            load byte/halfword extraction with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  i_st_addr_lo,
    input  logic [1:0]  i_save_option,
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [2:0]  i_load_option,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wdata = i_store_data;
        o_be    = 4'b1111;
        case (i_save_option)
            SAVE_SH: begin
                o_wdata = {2{i_store_data[15:0]}};
                o_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SAVE_SB: begin
                o_wdata = {4{i_store_data[7:0]}};
                o_be    = 4'b0001 << i_st_addr_lo;
            end
            default: ;
        endcase
    end

    // Halfword selection only looks at addr[1], so an odd halfword address folds down.
    assign w_byte = i_rdata[8*i_ld_addr_lo +: 8];
    assign w_half = i_rdata[16*i_ld_addr_lo[1] +: 16];

    always_comb begin
        o_load_data = i_rdata;
        case (i_load_option)
            LOAD_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            LOAD_LHU: o_load_data = {16'h0000, w_half};
            LOAD_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: o_load_data = {24'h000000, w_byte};
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MEM pipeline stage; runs loads/stores over a req/ack data bus with
//            timeout, stalls the pipeline while busy. Optional misaligned-access
//            trap enabled by defining MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import cpu_mem_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        M_MemWrite,
    input  logic        M_MemtoReg,
    input  logic [31:0] M_ALUanswer,
    input  logic [31:0] M_Qb,
    input  logic [2:0]  M_load_option,
    input  logic [1:0]  M_save_option,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic [31:0] M_LoadData,
    output logic        bus_err,
    output logic        misalign
);

    localparam int                 c_CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    mem_state_t         r_state,     w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_mem_req,   w_mem_req_nxt;
    logic               r_mem_we,    w_mem_we_nxt;
    logic [31:0]        r_mem_addr,  w_mem_addr_nxt;
    logic [31:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]         r_mem_be,    w_mem_be_nxt;
    logic [31:0]        r_load_data, w_load_data_nxt;
    logic               r_bus_err,   w_bus_err_nxt;
    logic               r_misalign,  w_misalign_nxt;
    logic               r_is_load,   w_is_load_nxt;
    logic [2:0]         r_ld_opt,    w_ld_opt_nxt;
    logic [1:0]         r_ld_off,    w_ld_off_nxt;

    logic               w_access;
    logic               w_trap;
    logic [31:0]        w_st_wdata;
    logic [3:0]         w_st_be;
    logic [31:0]        w_ld_fmt;

    assign w_access  = M_MemWrite | M_MemtoReg;
    assign w_cnt_inc = r_cnt + c_CNT_ONE;

`ifdef MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(M_ALUanswer[1:0], M_MemWrite, M_load_option, M_save_option);
`else
    assign w_trap = 1'b0;
`endif

    // Store side formats the live EX/MEM operands; load side uses the latched offset/option.
    mem_lane_align u_lane_align (
        .i_st_addr_lo  (M_ALUanswer[1:0]),
        .i_save_option (M_save_option),
        .i_store_data  (M_Qb),
        .i_ld_addr_lo  (r_ld_off),
        .i_load_option (r_ld_opt),
        .i_rdata       (mem_rdata),
        .o_wdata       (w_st_wdata),
        .o_be          (w_st_be),
        .o_load_data   (w_ld_fmt)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'h0;
            r_load_data <= 32'h0;
            r_bus_err   <= 1'b0;
            r_misalign  <= 1'b0;
            r_is_load   <= 1'b0;
            r_ld_opt    <= 3'h0;
            r_ld_off    <= 2'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_load_data <= w_load_data_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_misalign  <= w_misalign_nxt;
            r_is_load   <= w_is_load_nxt;
            r_ld_opt    <= w_ld_opt_nxt;
            r_ld_off    <= w_ld_off_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_load_data_nxt = r_load_data;
        w_is_load_nxt   = r_is_load;
        w_ld_opt_nxt    = r_ld_opt;
        w_ld_off_nxt    = r_ld_off;
        w_bus_err_nxt   = 1'b0;
        w_misalign_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_trap) begin
                        w_state_nxt     = ST_DONE;
                        w_misalign_nxt  = 1'b1;
                        w_load_data_nxt = 32'h0;
                    end else begin
                        w_state_nxt     = ST_WAIT;
                        w_cnt_nxt       = '0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = M_MemWrite;
                        w_mem_addr_nxt  = {M_ALUanswer[31:2], 2'b00};
                        w_mem_wdata_nxt = w_st_wdata;
                        w_mem_be_nxt    = w_st_be;
                        w_is_load_nxt   = ~M_MemWrite;
                        w_ld_opt_nxt    = M_load_option;
                        w_ld_off_nxt    = M_ALUanswer[1:0];
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                    if (r_is_load) begin
                        w_load_data_nxt = w_ld_fmt;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_CNT_LIMIT) begin
                        w_mem_req_nxt   = 1'b0;
                        w_load_data_nxt = 32'h0;
                        w_bus_err_nxt   = 1'b1;
                        w_state_nxt     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Dropping stall in DONE lets the pipeline advance on the edge that returns us to IDLE.
    assign mem_stall  = w_access & (r_state != ST_DONE);

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign M_LoadData = r_load_data;
    assign bus_err    = r_bus_err;
    assign misalign   = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Self-checking bench for mem_access_stage: directed cases plus
//            randomized loads/stores against a behavioural memory-stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int MAX_WAIT = 16;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        M_MemWrite = 1'b0;
    logic        M_MemtoReg = 1'b0;
    logic [31:0] M_ALUanswer = 32'h0;
    logic [31:0] M_Qb = 32'h0;
    logic [2:0]  M_load_option = 3'h0;
    logic [1:0]  M_save_option = 2'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_stall;
    logic [31:0] M_LoadData;
    logic        bus_err;
    logic        misalign;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .M_MemWrite    (M_MemWrite),
        .M_MemtoReg    (M_MemtoReg),
        .M_ALUanswer   (M_ALUanswer),
        .M_Qb          (M_Qb),
        .M_load_option (M_load_option),
        .M_save_option (M_save_option),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .mem_stall     (mem_stall),
        .M_LoadData    (M_LoadData),
        .bus_err       (bus_err),
        .misalign      (misalign)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_name = "reset";
    logic [31:0] model_ld = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%08h, expected 0x%08h", cur_name, tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [31:0] exp_load(input int opt, input int off, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * off)) % 256;
        h = (rd >> (16 * (off / 2))) % 65536;
        case (opt)
            1:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
            2:       return h;
            3:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4:       return b;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input int opt, input int off);
        case (opt)
            1:       return (off >= 2) ? 4'hC : 4'h3;
            2:       return 4'(2 ** off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input int opt, input logic [31:0] qb);
        case (opt)
            1:       return (qb % 65536) * 32'h00010001;
            2:       return (qb % 256) * 32'h01010101;
            default: return qb;
        endcase
    endfunction

    function automatic bit model_trap(input bit is_store, input int opt, input int off);
        if (!TRAP_EN) return 1'b0;
        if (is_store) return (opt == 1) ? (off % 2 == 1) : (opt == 2) ? 1'b0 : (off != 0);
        return (opt == 1 || opt == 2) ? (off % 2 == 1) : (opt == 3 || opt == 4) ? 1'b0 : (off != 0);
    endfunction

    // Entered and left at 1ns after a rising edge with the stage in IDLE.
    // delay = WAIT cycle in which ack is returned (1..MAX_WAIT), 0 = never.
    task automatic do_access(input string name, input bit is_store, input int opt,
                             input logic [31:0] addr, input logic [31:0] qb,
                             input int delay, input logic [31:0] rdata);
        int off, exp_wait, wait_n;
        bit trap, first, finished;
        cur_name = name;
        off      = int'(addr % 4);
        trap     = model_trap(is_store, opt, off);
        exp_wait = trap ? 0 : ((delay == 0) ? MAX_WAIT : delay);

        M_MemWrite    = is_store;
        M_MemtoReg    = !is_store;
        M_ALUanswer   = addr;
        M_Qb          = qb;
        M_load_option = is_store ? 3'($urandom_range(0, 7)) : 3'(opt);
        M_save_option = is_store ? 2'(opt) : 2'($urandom_range(0, 3));
        mem_ack       = 1'b0;
        #1;
        check_eq("stall_idle", 32'(mem_stall), 32'd1);

        @(posedge Clk); #1;
        first = 1'b1; finished = 1'b0; wait_n = 0;
        for (int i = 0; i < MAX_WAIT + 4 && !finished; i++) begin
            if (!mem_stall) begin
                finished = 1'b1;
            end else begin
                if (first) begin
                    check_eq("req", 32'(mem_req), 32'd1);
                    check_eq("addr", mem_addr, (addr / 4) * 4);
                    check_eq("we", 32'(mem_we), 32'(is_store));
                    if (is_store) begin
                        check_eq("be", 32'(mem_be), 32'(exp_be(opt, off)));
                        check_eq("wdata", mem_wdata, exp_wdata(opt, qb));
                    end
                    first = 1'b0;
                end else begin
                    check_eq("req_hold", 32'(mem_req), 32'd1);
                    check_eq("addr_hold", mem_addr, (addr / 4) * 4);
                end
                wait_n++;
                if (delay != 0 && wait_n == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                @(posedge Clk); #1;
                mem_ack = 1'b0;
            end
        end

        check_eq("done_reached", 32'(finished), 32'd1);
        check_eq("wait_cycles", 32'(wait_n), 32'(exp_wait));
        check_eq("req_done", 32'(mem_req), 32'd0);
        check_eq("bus_err", 32'(bus_err), 32'(delay == 0 && !trap));
        check_eq("misalign", 32'(misalign), 32'(trap));
        if (trap || delay == 0) model_ld = 32'h0;
        else if (!is_store)     model_ld = exp_load(opt, off, rdata);
        check_eq("load_data", M_LoadData, model_ld);

        // A stray ack outside WAIT must have no effect.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(posedge Clk); #1;
        mem_ack = 1'b0;
        check_eq("bus_err_pulse", 32'(bus_err), 32'd0);
        check_eq("misalign_pulse", 32'(misalign), 32'd0);
        check_eq("req_after", 32'(mem_req), 32'd0);
        check_eq("load_hold", M_LoadData, model_ld);
    endtask

    task automatic idle_cycles(input int n);
        cur_name   = "idle";
        M_MemWrite = 1'b0;
        M_MemtoReg = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            check_eq("idle_stall", 32'(mem_stall), 32'd0);
            @(posedge Clk); #1;
            mem_ack = 1'b0;
            check_eq("idle_req", 32'(mem_req), 32'd0);
        end
    endtask

    task automatic reset_mid_access();
        cur_name    = "reset_mid";
        M_MemWrite  = 1'b0;
        M_MemtoReg  = 1'b1;
        M_load_option = 3'd0;
        M_ALUanswer = 32'h0000_2004;
        mem_ack     = 1'b0;
        @(posedge Clk); #1;
        check_eq("req_before", 32'(mem_req), 32'd1);
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset      = 1'b1;
        M_MemtoReg = 1'b0;
        mem_ack    = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_eq("req", 32'(mem_req), 32'd0);
        check_eq("we", 32'(mem_we), 32'd0);
        check_eq("addr", mem_addr, 32'h0);
        check_eq("wdata", mem_wdata, 32'h0);
        check_eq("be", 32'(mem_be), 32'd0);
        check_eq("load_data", M_LoadData, 32'h0);
        check_eq("stall", 32'(mem_stall), 32'd0);
        @(posedge Clk); #1;
        mem_ack  = 1'b0;
        model_ld = 32'h0;
        check_eq("req_post", 32'(mem_req), 32'd0);
        check_eq("load_post", M_LoadData, model_ld);
        check_eq("bus_err_post", 32'(bus_err), 32'd0);
    endtask

    initial begin
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("req", 32'(mem_req), 32'd0);
        check_eq("we", 32'(mem_we), 32'd0);
        check_eq("addr", mem_addr, 32'h0);
        check_eq("wdata", mem_wdata, 32'h0);
        check_eq("be", 32'(mem_be), 32'd0);
        check_eq("load_data", M_LoadData, 32'h0);
        check_eq("bus_err", 32'(bus_err), 32'd0);
        check_eq("misalign", 32'(misalign), 32'd0);
        check_eq("stall", 32'(mem_stall), 32'd0);
        Reset = 1'b1;
        idle_cycles(2);

        do_access("sb_103",   1'b1, 2, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0);
        do_access("lb_102",   1'b0, 3, 32'h0000_0102, 32'h0,         1, 32'h12F0_3456);
        do_access("lbu_102",  1'b0, 4, 32'h0000_0102, 32'h0,         3, 32'h12F0_3456);
        do_access("lhu_102",  1'b0, 2, 32'h0000_0102, 32'h0,         1, 32'h12F0_3456);
        do_access("lh_100",   1'b0, 1, 32'h0000_0100, 32'h0,         2, 32'h1234_8001);
        reset_mid_access();
        idle_cycles(1);
        do_access("lw_noack", 1'b0, 0, 32'h0000_0400, 32'h0,         0, 32'h0);
        do_access("b2b_sw",   1'b1, 0, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'h0);
        do_access("b2b_lw",   1'b0, 0, 32'h0000_0204, 32'h0,         1, 32'h8765_4321);
        do_access("sh_102",   1'b1, 1, 32'h0000_0102, 32'h1234_BEEF, 1, 32'h0);
        do_access("sw_102",   1'b1, 0, 32'h0000_0102, 32'h1111_2222, 1, 32'h0);
        do_access("lw_full",  1'b0, 0, 32'h0000_0008, 32'h0,         MAX_WAIT, 32'hA5A5_0F0F);

        for (int t = 0; t < 40; t++) begin
            bit is_st;
            int opt, dly;
            is_st = 1'($urandom_range(0, 1));
            opt   = is_st ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
            dly   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            do_access("rand", is_st, opt, $urandom, $urandom, dly, $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
